// File: rtl/tm_transition_engine.sv
// Programmable Turing-machine control unit: (state, symbol) -> (next state, new symbol, move),
// sequenced against the tape unit with valid/ready handshakes.
module tm_transition_engine #(
    parameter int unsigned STATE_W = 3,
    parameter int unsigned SYM_W   = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       prog_we,
    input  logic [STATE_W+SYM_W-1:0]   prog_addr,
    input  logic [STATE_W+SYM_W+1:0]   prog_data,
    input  logic                       start,
    input  logic                       sym_valid,
    input  logic [SYM_W-1:0]           sym_in,
    output logic                       sym_ready,
    output logic                       wr_valid,
    output logic [SYM_W-1:0]           wr_sym,
    output logic [1:0]                 wr_move,
    input  logic                       wr_ready,
    output logic [STATE_W-1:0]         state_out,
    output logic                       busy,
    output logic                       halted,
    output logic [CNT_W-1:0]           steps
);

    localparam int unsigned ADDR_W  = STATE_W + SYM_W;
    localparam int unsigned ENTRY_W = ADDR_W + 2;
    localparam int unsigned DEPTH   = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOOKUP,
        S_EMIT,
        S_HALT
    } fsm_t;

    fsm_t                 fsm_q, fsm_d;
    logic [SYM_W-1:0]     sym_q, sym_d;
    logic [STATE_W-1:0]   next_q, next_d;
    logic [ENTRY_W-1:0]   table_q [DEPTH];
    logic [ENTRY_W-1:0]   entry;

    logic                 sym_ready_d, wr_valid_d, busy_d, halted_d;
    logic [SYM_W-1:0]     wr_sym_d;
    logic [1:0]           wr_move_d;
    logic [STATE_W-1:0]   state_d;
    logic [CNT_W-1:0]     steps_d;

    assign entry = table_q[{state_out, sym_q}];

    // Transition table; reset to all-ones so unprogrammed entries halt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                table_q[i] <= '1;
            end
        end else if (prog_we && !busy) begin
            table_q[prog_addr] <= prog_data;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q     <= S_IDLE;
            sym_q     <= '0;
            next_q    <= '0;
            sym_ready <= 1'b0;
            wr_valid  <= 1'b0;
            wr_sym    <= '0;
            wr_move   <= 2'b00;
            state_out <= '0;
            busy      <= 1'b0;
            halted    <= 1'b0;
            steps     <= '0;
        end else begin
            fsm_q     <= fsm_d;
            sym_q     <= sym_d;
            next_q    <= next_d;
            sym_ready <= sym_ready_d;
            wr_valid  <= wr_valid_d;
            wr_sym    <= wr_sym_d;
            wr_move   <= wr_move_d;
            state_out <= state_d;
            busy      <= busy_d;
            halted    <= halted_d;
            steps     <= steps_d;
        end
    end

    // Next-state and next-output decode; outputs are computed one cycle ahead
    always_comb begin
        fsm_d       = fsm_q;
        sym_d       = sym_q;
        next_d      = next_q;
        sym_ready_d = 1'b0;
        wr_valid_d  = 1'b0;
        wr_sym_d    = wr_sym;
        wr_move_d   = wr_move;
        state_d     = state_out;
        busy_d      = busy;
        halted_d    = halted;
        steps_d     = steps;

        unique case (fsm_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    fsm_d       = S_FETCH;
                    state_d     = '0;
                    steps_d     = '0;
                    halted_d    = 1'b0;
                    busy_d      = 1'b1;
                    sym_ready_d = 1'b1;
                end
            end
            S_FETCH: begin
                if (sym_valid && sym_ready) begin
                    sym_d = sym_in;
                    fsm_d = S_LOOKUP;
                end else begin
                    sym_ready_d = 1'b1;
                end
            end
            S_LOOKUP: begin
                next_d     = entry[ENTRY_W-1 -: STATE_W];
                wr_sym_d   = entry[SYM_W+1 -: SYM_W];
                wr_move_d  = entry[1:0];
                wr_valid_d = 1'b1;
                fsm_d      = S_EMIT;
            end
            S_EMIT: begin
                if (wr_valid && wr_ready) begin
                    state_d = next_q;
                    steps_d = (steps == '1) ? steps : steps + CNT_W'(1);
                    if (wr_move == 2'b11) begin
                        fsm_d    = S_HALT;
                        busy_d   = 1'b0;
                        halted_d = 1'b1;
                    end else begin
                        fsm_d       = S_FETCH;
                        sym_ready_d = 1'b1;
                    end
                end else begin
                    wr_valid_d = 1'b1;
                end
            end
            default: begin
                fsm_d  = S_IDLE;
                busy_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_tm_transition_engine.sv
// Bench for tm_transition_engine: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized programs and handshakes.
module tb_tm_transition_engine;

    localparam int unsigned SW = 3;
    localparam int unsigned YW = 3;
    localparam int unsigned CW = 4;

    logic           clk, rst_n;
    logic           prog_we;
    logic [5:0]     prog_addr;
    logic [7:0]     prog_data;
    logic           start, sym_valid, sym_ready, wr_valid, wr_ready, busy, halted;
    logic [2:0]     sym_in, wr_sym, state_out;
    logic [1:0]     wr_move;
    logic [3:0]     steps;

    int checks = 0;
    int errors = 0;

    tm_transition_engine #(.STATE_W(SW), .SYM_W(YW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .sym_valid(sym_valid), .sym_in(sym_in),
        .sym_ready(sym_ready), .wr_valid(wr_valid), .wr_sym(wr_sym), .wr_move(wr_move),
        .wr_ready(wr_ready), .state_out(state_out), .busy(busy), .halted(halted),
        .steps(steps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a run is "awaiting symbol" -> "symbol in hand" -> "command posted"
    bit         m_want, m_have, m_cmd, m_busy, m_halt;
    logic [2:0] m_st, m_sym, m_csym, m_next;
    logic [1:0] m_cmove;
    logic [3:0] m_steps;
    logic [7:0] m_tab [64];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task model_reset();
        m_want = 0; m_have = 0; m_cmd = 0; m_busy = 0; m_halt = 0;
        m_st = 0; m_sym = 0; m_csym = 0; m_next = 0; m_cmove = 0; m_steps = 0;
        for (int i = 0; i < 64; i++) m_tab[i] = 8'hFF;
    endtask

    // Advance the model by one clock using the inputs about to be sampled
    task model_step();
        logic [7:0] e;
        if (!m_busy) begin
            if (prog_we) m_tab[prog_addr] = prog_data;
            if (start) begin
                m_busy = 1; m_want = 1; m_halt = 0; m_st = 0; m_steps = 0;
            end
        end else if (m_want) begin
            if (sym_valid) begin
                m_want = 0; m_have = 1; m_sym = sym_in;
            end
        end else if (m_have) begin
            e = m_tab[{m_st, m_sym}];
            m_have = 0; m_cmd = 1;
            m_next = e[7:5]; m_csym = e[4:2]; m_cmove = e[1:0];
        end else if (m_cmd && wr_ready) begin
            m_cmd = 0;
            m_st = m_next;
            if (m_steps != 4'hF) m_steps = m_steps + 4'd1;
            if (m_cmove == 2'b11) begin
                m_busy = 0; m_halt = 1;
            end else begin
                m_want = 1;
            end
        end
    endtask

    task compare_all();
        chk("sym_ready", 32'(sym_ready), 32'(m_want));
        chk("wr_valid", 32'(wr_valid), 32'(m_cmd));
        if (m_cmd) begin
            chk("wr_sym", 32'(wr_sym), 32'(m_csym));
            chk("wr_move", 32'(wr_move), 32'(m_cmove));
        end
        chk("state_out", 32'(state_out), 32'(m_st));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("halted", 32'(halted), 32'(m_halt));
        chk("steps", 32'(steps), 32'(m_steps));
        if (sym_ready && wr_valid) chk("ready_valid_overlap", 32'(1), 32'(0));
    endtask

    task tick();
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task idle_in();
        start = 0; prog_we = 0; prog_addr = 0; prog_data = 0;
        sym_valid = 0; sym_in = 0; wr_ready = 0;
    endtask

    task prog(input logic [5:0] a, input logic [7:0] d);
        prog_we = 1; prog_addr = a; prog_data = d;
    endtask

    // Asynchronous reset taken between clock edges; outputs must clear immediately
    task do_reset();
        rst_n = 0;
        #1;
        chk("rst_sym_ready", 32'(sym_ready), 32'd0);
        chk("rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_wr_sym", 32'(wr_sym), 32'd0);
        chk("rst_wr_move", 32'(wr_move), 32'd0);
        chk("rst_state_out", 32'(state_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_steps", 32'(steps), 32'd0);
        model_reset();
        idle_in();
        @(negedge clk);
        rst_n = 1;
        compare_all();
    endtask

    initial begin
        rst_n = 0;
        idle_in();
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // Run into EMIT, then reset mid-command
        prog(6'o01, {3'd1, 3'd2, 2'b10}); tick();
        idle_in(); start = 1; tick();
        chk("start_to_ready", 32'(sym_ready), 32'd1);
        idle_in(); sym_valid = 1; sym_in = 3'd1; tick();
        idle_in(); tick();
        chk("emit_before_reset", 32'(wr_valid), 32'd1);
        do_reset();

        // Table is back to all-ones: any symbol halts after one write of 7
        idle_in(); start = 1; tick();
        idle_in(); sym_valid = 1; sym_in = 3'd0; tick();
        idle_in(); tick();
        chk("blank_wr_sym", 32'(wr_sym), 32'd7);
        chk("blank_wr_move", 32'(wr_move), 32'd3);
        idle_in(); wr_ready = 1; tick();
        chk("blank_halted", 32'(halted), 32'd1);
        chk("blank_steps", 32'(steps), 32'd1);
        chk("blank_state", 32'(state_out), 32'd7);

        // Two-step program; second write lands in the same cycle as start (restart from HALT)
        idle_in(); prog(6'o01, {3'd1, 3'd2, 2'b10}); tick();
        idle_in(); prog(6'o10, {3'd1, 3'd3, 2'b11}); start = 1; tick();
        chk("restart_ready", 32'(sym_ready), 32'd1);
        chk("restart_steps", 32'(steps), 32'd0);
        chk("restart_halted", 32'(halted), 32'd0);
        chk("restart_state", 32'(state_out), 32'd0);
        idle_in(); sym_valid = 1; sym_in = 3'd1; tick();
        idle_in(); tick();
        chk("step1_wr_sym", 32'(wr_sym), 32'd2);
        chk("step1_wr_move", 32'(wr_move), 32'd2);
        // Backpressure: command held, state and count frozen
        for (int i = 0; i < 5; i++) begin
            idle_in(); tick();
            chk("bp_valid", 32'(wr_valid), 32'd1);
            chk("bp_wr_sym", 32'(wr_sym), 32'd2);
            chk("bp_state", 32'(state_out), 32'd0);
            chk("bp_steps", 32'(steps), 32'd0);
        end
        idle_in(); wr_ready = 1; tick();
        chk("step1_state", 32'(state_out), 32'd1);
        chk("step1_steps", 32'(steps), 32'd1);
        idle_in(); sym_valid = 1; sym_in = 3'd0; tick();
        idle_in(); tick();
        chk("step2_wr_sym", 32'(wr_sym), 32'd3);
        chk("step2_wr_move", 32'(wr_move), 32'd3);
        idle_in(); wr_ready = 1; tick();
        chk("two_halted", 32'(halted), 32'd1);
        chk("two_steps", 32'(steps), 32'd2);
        chk("two_state", 32'(state_out), 32'd1);
        chk("two_busy", 32'(busy), 32'd0);

        // Program lockout while busy, then the same write taking effect when idle
        idle_in(); start = 1; tick();
        idle_in(); prog(6'o01, {3'd0, 3'd5, 2'b11}); sym_valid = 1; sym_in = 3'd1; tick();
        idle_in(); tick();
        chk("lock_wr_sym", 32'(wr_sym), 32'd2);
        idle_in(); wr_ready = 1; tick();
        idle_in(); sym_valid = 1; sym_in = 3'd0; tick();
        idle_in(); tick();
        idle_in(); wr_ready = 1; tick();
        idle_in(); prog(6'o01, {3'd0, 3'd5, 2'b11}); tick();
        idle_in(); start = 1; tick();
        idle_in(); sym_valid = 1; sym_in = 3'd1; tick();
        idle_in(); tick();
        chk("unlock_wr_sym", 32'(wr_sym), 32'd5);
        chk("unlock_wr_move", 32'(wr_move), 32'd3);
        idle_in(); wr_ready = 1; tick();
        chk("unlock_halted", 32'(halted), 32'd1);

        // Self-loop: step counter must stick at all-ones
        idle_in(); prog(6'o00, {3'd0, 3'd0, 2'b00}); tick();
        idle_in(); start = 1; tick();
        idle_in(); sym_valid = 1; sym_in = 3'd0; wr_ready = 1;
        repeat (60) tick();
        chk("sat_steps", 32'(steps), 32'd15);
        chk("sat_busy", 32'(busy), 32'd1);
        idle_in();
        do_reset();

        // Randomized programs and handshakes
        for (int i = 0; i < 64; i++) begin
            idle_in(); prog(6'(i), 8'($urandom)); tick();
        end
        for (int n = 0; n < 4000; n++) begin
            start     = ($urandom_range(0, 7) == 0);
            prog_we   = ($urandom_range(0, 15) == 0);
            prog_addr = 6'($urandom);
            prog_data = 8'($urandom);
            sym_valid = ($urandom_range(0, 9) < 7);
            sym_in    = 3'($urandom);
            wr_ready  = ($urandom_range(0, 9) < 6);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tm_transition_engine.md
# tm_transition_engine

Parametrised, sequential Turing-machine control unit for the universal Turing machine. It replaces hard-wired next-symbol logic with a run-time programmable transition table: (state, symbol) -> (next state, new symbol, head move). It sequences each step with the tape/head unit over valid/ready handshakes: fetch symbol, look up, emit write+move. It counts executed steps and flags halt.

## Interface
Parameters:
- STATE_W, 3, state index width; 2^STATE_W states, state 0 is the start state.
- SYM_W, 3, tape symbol width.
- CNT_W, 16, step counter width.
- Derived: ENTRY_W = STATE_W+SYM_W+2, table depth 2^(STATE_W+SYM_W); entry = {next_state, new_sym, move[1:0]}.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- prog_we  in  1  table write strobe.
- prog_addr  in  STATE_W+SYM_W  entry address = {state, symbol}.
- prog_data  in  ENTRY_W  entry contents.
- start  in  1  begin run from state 0 (level sampled).
- sym_valid  in  1  tape unit presents current symbol.
- sym_in  in  SYM_W  current symbol under head.
- sym_ready  out  1  engine accepts symbol.
- wr_valid  out  1  write/move command valid.
- wr_sym  out  SYM_W  symbol to write.
- wr_move  out  2  00 stay, 01 left, 10 right, 11 halt (write then stop).
- wr_ready  in  1  tape unit accepts command.
- state_out  out  STATE_W  current machine state.
- busy  out  1  run in progress.
- halted  out  1  run ended on a halt entry.
- steps  out  CNT_W  completed steps in current/last run.

## Operation
- FSM states: IDLE, FETCH, LOOKUP, EMIT, HALT.
- IDLE/HALT: start=1 -> FETCH; state_out<=0, steps<=0, halted<=0.
- FETCH: sym_ready=1; on sym_valid&sym_ready latch sym_in -> LOOKUP.
- LOOKUP: read table[{state_out, latched sym}] into entry register -> EMIT.
- EMIT: wr_valid=1, wr_sym/wr_move from entry register, held stable until wr_ready. On handshake: state_out<=next_state, steps<=steps+1 (saturating at all-ones, no wrap); move==11 -> HALT, else -> FETCH.
- busy=1 in FETCH, LOOKUP, EMIT. halted=1 only in HALT.
- Table writes: prog_we applies only when busy=0; ignored while busy. Write in the same cycle as start is committed (visible to first LOOKUP).
- start while busy ignored.
- Table reset contents: every entry all-ones (next_state max, new_sym max, move=11), so any unprogrammed entry halts after one write.

## Timing
- Reset (asynchronous, mid-run included): FSM=IDLE, sym_ready=0, wr_valid=0, wr_sym=0, wr_move=00, state_out=0, busy=0, halted=0, steps=0, table all-ones. In-flight command aborted, no partial handshake completes.
- Minimum step = 3 cycles (FETCH, LOOKUP, EMIT) with sym_valid and wr_ready held high.
- start sampled in cycle N -> sym_ready high in cycle N+1.
- sym_ready and wr_valid never high in the same cycle.
- Outputs are registered or decoded from FSM state only; no combinational path from sym_valid/wr_ready to any output.
- state_out and steps update in the cycle after the EMIT handshake.

## Test plan
- Reset values: assert rst_n=0 mid-EMIT -> all outputs at reset values same cycle; table reads all-ones afterwards (start, sym 0 -> wr_sym=7, wr_move=11, halted=1, steps=1).
- Two-step program: table[{0,1}]={1,2,10}, table[{1,0}]={1,3,11}; start, feed sym 1 then 0 -> writes (2, right) then (3, halt); state_out=1, steps=2, halted=1.
- Backpressure: hold wr_ready=0 for 5 cycles in EMIT -> wr_valid, wr_sym, wr_move stable; state_out/steps unchanged until handshake.
- Program lockout: prog_we to {0,1} while busy -> entry unchanged; same write in IDLE -> takes effect.
- Saturation: CNT_W=4, self-loop entry {0,0}={0,0,00}, constant sym 0 for 20 steps -> steps stops at 15.
- Restart from HALT: start=1 -> steps=0, halted=0, state_out=0, sym_ready=1 next cycle.
